acl2_spi_sequencer: RTL and testbench



---
 rtl/acl2_spi_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_acl2_spi_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/acl2_spi_sequencer.sv
// SPI sequencer for the PmodACL2 (ADXL362): configures measurement mode,
// then burst-reads X/Y/Z on each sample tick and publishes 12-bit samples.
//
// Ports:
//   clk, rst            system clock, async active-low reset
//   enable              allows sample reads once configuration is done
//   miso/mosi/sclk/cs_n SPI mode 0 link to the sensor, MSB first
//   x_data/y_data/z_data latched 12-bit two's complement samples
//   sample_valid        one-cycle pulse when x/y/z update
//   cfg_done            high once the configuration write has completed
//   busy                high while cs_n is low or the inter-frame gap runs
//   overrun             one-cycle pulse when a sample tick is dropped
module acl2_spi_sequencer #(
    parameter int CLK_DIV       = 6,
    parameter int SAMPLE_PERIOD = 100000,
    parameter int GAP_CYCLES    = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        miso,
    output logic        sclk,
    output logic        mosi,
    output logic        cs_n,
    output logic [11:0] x_data,
    output logic [11:0] y_data,
    output logic [11:0] z_data,
    output logic        sample_valid,
    output logic        cfg_done,
    output logic        busy,
    output logic        overrun
);

    localparam int DW = $clog2(CLK_DIV);
    localparam int TW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int GW = $clog2(GAP_CYCLES + 1);

    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
    localparam logic [TW-1:0] TMR_MAX = TW'(SAMPLE_PERIOD - 1);
    localparam logic [GW-1:0] GAP_MAX = GW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        CFG_START,
        XFER,
        GAP,
        WAIT,
        DONE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [DW-1:0] r_div;
    logic [7:0]    r_edge;
    logic [GW-1:0] r_gap;
    logic [TW-1:0] r_tmr;
    logic [63:0]   r_tx;
    logic [47:0]   r_rx;
    logic          r_sclk;
    logic          r_cs_n;
    logic          r_is_cfg;
    logic          r_cfg_done;
    logic          r_pending;
    logic          r_valid;
    logic          r_ovr;
    logic [11:0]   r_x;
    logic [11:0]   r_y;
    logic [11:0]   r_z;

    logic          w_div_wrap;
    logic [7:0]    w_edges;
    logic          w_xfer_end;
    logic          w_gap_end;
    logic          w_tick;
    logic          w_start_rd;
    logic          w_unused;

    // One sclk toggle per divider wrap; 16 toggles per byte plus
    // a final wrap that raises cs_n.
    assign w_div_wrap = (r_div == DIV_MAX);
    assign w_edges    = r_is_cfg ? 8'd48 : 8'd128;
    assign w_xfer_end = (r_state == XFER) && w_div_wrap
                        && (r_edge == w_edges);
    assign w_gap_end  = (r_state == GAP) && (r_gap == GAP_MAX);
    assign w_tick     = r_cfg_done && (r_tmr == TMR_MAX);
    assign w_start_rd = (r_state == WAIT) && r_pending && enable;

    // Only the low nibble of each high byte is part of a sample.
    assign w_unused = ^{r_rx[39:36], r_rx[23:20], r_rx[7:4]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= CFG_START;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            CFG_START: w_state_nxt = XFER;
            XFER: begin
                if (w_xfer_end) w_state_nxt = GAP;
            end
            GAP: begin
                if (w_gap_end) w_state_nxt = r_is_cfg ? WAIT : DONE;
            end
            WAIT: begin
                if (w_start_rd) w_state_nxt = XFER;
            end
            DONE:    w_state_nxt = WAIT;
            default: w_state_nxt = CFG_START;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div      <= '0;
            r_edge     <= '0;
            r_gap      <= '0;
            r_tmr      <= '0;
            r_tx       <= '0;
            r_rx       <= '0;
            r_sclk     <= 1'b0;
            r_cs_n     <= 1'b1;
            r_is_cfg   <= 1'b0;
            r_cfg_done <= 1'b0;
            r_pending  <= 1'b0;
            r_valid    <= 1'b0;
            r_ovr      <= 1'b0;
            r_x        <= '0;
            r_y        <= '0;
            r_z        <= '0;
        end else begin
            r_valid <= 1'b0;
            // A tick coinciding with a read start is not a dropped tick.
            r_ovr   <= w_tick & r_pending & ~w_start_rd;

            if (r_cfg_done) begin
                r_tmr <= w_tick ? '0 : r_tmr + 1'b1;
            end

            if (w_tick) begin
                r_pending <= 1'b1;
            end else if (w_start_rd) begin
                r_pending <= 1'b0;
            end

            if ((r_state == XFER) && !w_div_wrap) begin
                r_div <= r_div + 1'b1;
            end else begin
                r_div <= '0;
            end

            case (r_state)
                CFG_START: begin
                    r_tx     <= {24'h0A2D02, 40'h0};
                    r_is_cfg <= 1'b1;
                    r_cs_n   <= 1'b0;
                    r_edge   <= '0;
                end
                XFER: begin
                    if (w_div_wrap) begin
                        if (w_xfer_end) begin
                            r_cs_n <= 1'b1;
                            r_gap  <= '0;
                        end else begin
                            r_sclk <= ~r_sclk;
                            r_edge <= r_edge + 8'd1;
                            if (!r_sclk) begin
                                r_rx <= {r_rx[46:0], miso};
                            end else begin
                                r_tx <= {r_tx[62:0], 1'b0};
                            end
                        end
                    end
                end
                GAP: begin
                    r_gap <= r_gap + 1'b1;
                    if (w_gap_end && r_is_cfg) begin
                        r_cfg_done <= 1'b1;
                    end
                end
                WAIT: begin
                    if (w_start_rd) begin
                        r_tx     <= {16'h0B0E, 48'h0};
                        r_is_cfg <= 1'b0;
                        r_cs_n   <= 1'b0;
                        r_edge   <= '0;
                    end
                end
                DONE: begin
                    // r_rx holds received bytes 3..8 in order
                    r_x     <= {r_rx[35:32], r_rx[47:40]};
                    r_y     <= {r_rx[19:16], r_rx[31:24]};
                    r_z     <= {r_rx[3:0], r_rx[15:8]};
                    r_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign sclk         = r_sclk;
    assign mosi         = r_tx[63];
    assign cs_n         = r_cs_n;
    assign x_data       = r_x;
    assign y_data       = r_y;
    assign z_data       = r_z;
    assign sample_valid = r_valid;
    assign cfg_done     = r_cfg_done;
    assign busy         = (r_state == XFER) || (r_state == GAP);
    assign overrun      = r_ovr;

endmodule

// File: tb/tb_acl2_spi_sequencer.sv
// Bench for acl2_spi_sequencer: sensor model on the SPI pins plus a
// frame-level reference of timing, sample decoding and tick bookkeeping.
module tb_acl2_spi_sequencer;

    localparam int CLK_DIV = 2;
    localparam int PERIOD  = 400;
    localparam int GAP     = 12;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        miso = 1'b0;
    logic        sclk;
    logic        mosi;
    logic        cs_n;
    logic [11:0] x_data;
    logic [11:0] y_data;
    logic [11:0] z_data;
    logic        sample_valid;
    logic        cfg_done;
    logic        busy;
    logic        overrun;

    acl2_spi_sequencer #(
        .CLK_DIV(CLK_DIV),
        .SAMPLE_PERIOD(PERIOD),
        .GAP_CYCLES(GAP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .miso(miso),
        .sclk(sclk),
        .mosi(mosi),
        .cs_n(cs_n),
        .x_data(x_data),
        .y_data(y_data),
        .z_data(z_data),
        .sample_valid(sample_valid),
        .cfg_done(cfg_done),
        .busy(busy),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [35:0] xyz(input logic [63:0] r);
        logic [7:0] b[8];
        for (int i = 0; i < 8; i++) b[i] = r[63-8*i -: 8];
        return {b[3][3:0], b[2], b[5][3:0], b[4], b[7][3:0], b[6]};
    endfunction

    // Sensor: random reply per frame, shifted out on sclk falls;
    // mosi captured on sclk rises.
    logic [63:0] s_resp, s_resp0, s_mcap;
    int          s_rises;
    logic        s_pcs = 1'b1;
    logic        s_psclk = 1'b0;

    always @(posedge clk) begin
        #1;
        if (s_pcs && !cs_n) begin
            s_resp  = {$urandom, $urandom};
            s_resp0 = s_resp;
            miso    = s_resp[63];
            s_mcap  = '0;
            s_rises = 0;
        end else if (!cs_n) begin
            if (sclk && !s_psclk) begin
                s_mcap = {s_mcap[62:0], mosi};
                s_rises++;
            end
            if (!sclk && s_psclk) begin
                s_resp = s_resp << 1;
                miso   = s_resp[63];
            end
        end
        s_pcs   = cs_n;
        s_psclk = sclk;
    end

    logic en_s;
    always @(posedge clk) en_s <= enable;

    int          cyc, fall_cyc, since_rise, m, stall, nb;
    int          n_rd_falls = 0;
    int          n_ovr = 0;
    int          n_valid = 0;
    bit          pm, p_cs, p_cfg, p_valid, p_busy, in_rd;
    bit          tick, fall, rise, rd_start, exp_ovr, idle;
    logic [35:0] expq[$];
    logic [35:0] last;

    always @(negedge clk) begin
        if (!rst) begin
            cyc = 0; fall_cyc = 0; since_rise = 1000000; m = 0;
            stall = 0; pm = 0; p_cs = 1; p_cfg = 0; p_valid = 0;
            p_busy = 0; in_rd = 0; last = '0;
            expq.delete();
        end else begin
            cyc++;
            fall = p_cs && !cs_n;
            rise = !p_cs && cs_n;
            rd_start = fall && cfg_done;
            tick = 0;
            if (cfg_done) begin
                if (p_cfg) begin
                    m++;
                    tick = (m % PERIOD == 0);
                end else begin
                    m = 0;
                end
            end
            if (rise) since_rise = 0;
            else if (since_rise < 1000000) since_rise++;

            exp_ovr = tick && pm && !rd_start;
            if (overrun || exp_ovr)
                check("overrun", 64'(overrun), 64'(exp_ovr));
            if (overrun) n_ovr++;

            idle = p_cfg && p_cs && !p_busy;
            if (rd_start) begin
                check("start_pend", 64'(pm), 64'd1);
                check("start_en", 64'(en_s), 64'd1);
                check("start_lat", 64'(stall <= 1), 64'd1);
                check("hold_xyz", 64'({x_data, y_data, z_data}), 64'(last));
                n_rd_falls++;
                stall = 0;
            end else if (idle && pm && en_s) begin
                stall++;
                if (stall == 4) check("start_stuck", 64'(stall), 64'd1);
            end else begin
                stall = 0;
            end

            if (fall) begin
                check("gap_min", 64'(since_rise >= GAP), 64'd1);
                fall_cyc = cyc;
                in_rd = cfg_done;
            end
            if (tick) pm = 1;
            else if (rd_start) pm = 0;

            check("busy", 64'(busy), 64'(!cs_n || since_rise < GAP));

            if (rise) begin
                nb = in_rd ? 8 : 3;
                check("cs_low", 64'(cyc - fall_cyc),
                      64'(CLK_DIV * (1 + 16 * nb)));
                check("rises", 64'(s_rises), 64'(8 * nb));
                check("mosi", s_mcap,
                      in_rd ? 64'h0B0E_0000_0000_0000 : 64'h0A2D02);
                if (in_rd) expq.push_back(xyz(s_resp0));
            end
            if (cfg_done && !p_cfg) check("cfg_gap", 64'(since_rise), 64'(GAP));

            if (sample_valid) begin
                check("valid_pulse", 64'(p_valid), 64'd0);
                if (expq.size() == 0) begin
                    check("valid_q", 64'd0, 64'd1);
                end else begin
                    last = expq.pop_front();
                    check("xyz", 64'({x_data, y_data, z_data}), 64'(last));
                end
                n_valid++;
            end
            p_cs = cs_n; p_cfg = cfg_done;
            p_valid = sample_valid; p_busy = busy;
        end
    end

    int f0, o0, v0;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_cs_n", 64'(cs_n), 64'd1);
        check("rst_sclk", 64'(sclk), 64'd0);
        check("rst_mosi", 64'(mosi), 64'd0);
        check("rst_xyz", 64'({x_data, y_data, z_data}), 64'd0);
        check("rst_valid", 64'(sample_valid), 64'd0);
        check("rst_cfg", 64'(cfg_done), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ovr", 64'(overrun), 64'd0);
        rst = 1'b1;

        for (int i = 0; i < 400 && !cfg_done; i++) @(negedge clk);
        check("cfg_to", 64'(cfg_done), 64'd1);

        f0 = n_rd_falls;
        o0 = n_ovr;
        repeat (3 * PERIOD + 10) @(negedge clk);
        check("idle_falls", 64'(n_rd_falls - f0), 64'd0);
        check("idle_ovr", 64'(n_ovr > o0), 64'd1);

        enable = 1'b1;
        @(negedge clk);
        check("start_now", 64'(cs_n), 64'd0);

        for (int k = 0; k < 12; k++) begin
            enable = ($urandom_range(0, 3) != 0);
            repeat ($urandom_range(100, 900)) @(negedge clk);
        end

        enable = 1'b1;
        for (int i = 0; i < 1000 && !(!cs_n && cfg_done); i++)
            @(negedge clk);
        check("rd_seen", 64'(cs_n), 64'd0);
        enable = 1'b0;
        v0 = n_valid;
        for (int i = 0; i < 400 && n_valid == v0; i++) @(negedge clk);
        check("drop_valid", 64'(n_valid > v0), 64'd1);
        f0 = n_rd_falls;
        repeat (1000) @(negedge clk);
        check("drop_falls", 64'(n_rd_falls - f0), 64'd0);

        enable = 1'b1;
        for (int i = 0; i < 400 && !cs_n; i++) @(negedge clk);
        for (int i = 0; i < 1000 && cs_n; i++) @(negedge clk);
        check("rd2_seen", 64'(cs_n), 64'd0);
        repeat (CLK_DIV * (1 + 16 * 4) + 5) @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_cs_n", 64'(cs_n), 64'd1);
        check("mid_sclk", 64'(sclk), 64'd0);
        check("mid_xyz", 64'({x_data, y_data, z_data}), 64'd0);
        check("mid_cfg", 64'(cfg_done), 64'd0);
        check("mid_busy", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 400 && !cfg_done; i++) @(negedge clk);
        check("cfg_again", 64'(cfg_done), 64'd1);
        check("post_xyz", 64'({x_data, y_data, z_data}), 64'd0);
        v0 = n_valid;
        for (int i = 0; i < 1000 && n_valid == v0; i++) @(negedge clk);
        check("post_valid", 64'(n_valid > v0), 64'd1);
        check("samples", 64'(n_valid >= 5), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
